// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// MMIO register offsets, STATUS bit positions, decode regions, FIFO states.
package dmem_pkg;

  localparam int OFF_TXDATA = 0;
  localparam int OFF_STATUS = 1;
  localparam int OFF_CYCLE  = 2;
  localparam int OFF_CLEAR  = 3;

  localparam int ST_CNT_LSB = 0;
  localparam int ST_CNT_MSB = 7;
  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVF     = 10;
  localparam int ST_OOB     = 11;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_OOB
  } region_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Parameterised synchronous FIFO with count-based EMPTY/PARTIAL/FULL state.
// Head shows zero when empty; push while full and pop while empty are dropped.
module tx_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  fifo_state_e   r_state;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_cnt_nxt;
  fifo_state_e   w_state_nxt;

  assign full  = (r_state == FIFO_FULL);
  assign empty = (r_state == FIFO_EMPTY);
  assign count = r_count;
  assign head  = empty ? '0 : r_mem[r_rd];

  // fullness/emptiness judged on pre-edge state
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_comb begin
    w_cnt_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_state_nxt = FIFO_PARTIAL;
    if (w_cnt_nxt == '0)
      w_state_nxt = FIFO_EMPTY;
    else if (w_cnt_nxt == (AW+1)'(DEPTH))
      w_state_nxt = FIFO_FULL;
  end

  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_state <= FIFO_EMPTY;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      r_count <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCLE, CLEAR).
// MMIO window is built only when DMEM_MMIO_EN is defined; otherwise it decodes OOB.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err_flag
);

  localparam int DEPTH_W = 1 << ADDR_W;

  logic [31:0]       r_ram [DEPTH_W];
  logic [31:0]       r_q;
  logic              r_oob;
  logic              r_err;

  region_e           w_region;
  logic [ADDR_W-1:0] w_idx;
  logic              w_is_ram;
  logic              w_is_mmio;
  logic [31:0]       w_rdata;
  logic              w_oob_ev;
  logic              w_oob_nxt;

  assign w_idx    = address_dmem[ADDR_W-1:0];
  assign w_is_ram = (address_dmem[31:ADDR_W] == '0);
  assign w_oob_ev = (w_region == REGION_OOB);
  assign q_dmem   = r_q;
  assign err_flag = r_err;

`ifdef DMEM_MMIO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] w_off;
  logic [1:0]  w_sel;
  logic        w_mmio_wr;
  logic        w_push;
  logic        w_clr;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_cnt;
  logic [31:0] w_head;
  logic [31:0] w_status;
  logic        w_ovf_nxt;
  logic        r_ovf;
  logic [31:0] r_cycle;

  assign w_off     = address_dmem - MMIO_BASE;
  assign w_sel     = w_off[1:0];
  assign w_is_mmio = (w_off[31:2] == '0);
  assign w_mmio_wr = wren && (w_region == REGION_MMIO);
  assign w_push    = w_mmio_wr && (w_sel == 2'(OFF_TXDATA));
  assign w_clr     = w_mmio_wr && (w_sel == 2'(OFF_CLEAR));

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .wdata (data),
    .pop   (tx_ready),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt),
    .head  (w_head)
  );

  assign tx_valid = !w_empty;
  assign tx_data  = w_head;

  always_comb begin
    w_status = '0;
    w_status[ST_CNT_MSB:ST_CNT_LSB] = 8'(w_cnt);
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_OOB]   = r_oob;
  end

  // a new event in the same cycle as CLEAR leaves the bit set
  assign w_ovf_nxt = (r_ovf && !w_clr) || (w_push && w_full);
  assign w_oob_nxt = (r_oob && !w_clr) || w_oob_ev;
`else
  logic w_unused;

  assign w_is_mmio = 1'b0;
  assign tx_valid  = 1'b0;
  assign tx_data   = '0;
  assign w_unused  = tx_ready;
  assign w_oob_nxt = r_oob || w_oob_ev;
`endif

  always_comb begin
    w_region = REGION_OOB;
    if (w_is_ram)
      w_region = REGION_RAM;
    else if (w_is_mmio)
      w_region = REGION_MMIO;
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_region)
      REGION_RAM: w_rdata = wren ? data : r_ram[w_idx];
`ifdef DMEM_MMIO_EN
      REGION_MMIO: begin
        if (w_sel == 2'(OFF_STATUS))
          w_rdata = w_status;
        else if (w_sel == 2'(OFF_CYCLE))
          w_rdata = r_cycle;
      end
`endif
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wren && (w_region == REGION_RAM))
      r_ram[w_idx] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_oob <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_rdata;
      r_oob <= w_oob_nxt;
`ifdef DMEM_MMIO_EN
      r_err <= w_oob_nxt || w_ovf_nxt;
`else
      r_err <= w_oob_nxt;
`endif
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf   <= 1'b0;
      r_cycle <= '0;
    end else begin
      r_ovf   <= w_ovf_nxt;
      r_cycle <= r_cycle + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// MMIO scenarios run only when DMEM_MMIO_EN is defined.
module tb_dmem_responder;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0001;
  localparam logic [31:0] A_CYC = 32'hFFFF_0002;
  localparam logic [31:0] A_CLR = 32'hFFFF_0003;
  localparam logic [31:0] A_OOB = 32'h0000_2000;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err_flag;

  int n_tests;
  int n_fail;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .err_flag     (err_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    step();
    wren = 1'b0;
    address_dmem = '0;
  endtask

  task automatic rd(input logic [31:0] a);
    address_dmem = a;
    wren = 1'b0;
    step();
    address_dmem = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    address_dmem = '0;
    data = '0;
    wren = 1'b0;
    tx_ready = 1'b0;
    repeat (3) step();
    n_tests++;
    if (q_dmem !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 32'h0 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state q=%h v=%b d=%h e=%b req 0", q_dmem, tx_valid, tx_data, err_flag);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (err_flag !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset e=%b v=%b req 0/0", err_flag, tx_valid);
    end
  endtask

  task automatic test_ram();
    wr(32'd5, 32'hDEAD_BEEF);
    rd(32'd5);
    n_tests++;
    if (q_dmem !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ram_rd5 got %h req deadbeef", q_dmem);
    end
    address_dmem = 32'd7;
    data = 32'h1234;
    wren = 1'b1;
    step();
    wren = 1'b0;
    n_tests++;
    if (q_dmem !== 32'h1234) begin
      n_fail++;
      $display("FAIL write_first got %h req 1234", q_dmem);
    end
    wr(32'd4095, 32'hCAFE_0001);
    rd(32'd7);
    n_tests++;
    if (q_dmem !== 32'h1234) begin
      n_fail++;
      $display("FAIL ram_rd7 got %h req 1234", q_dmem);
    end
    rd(32'd4095);
    n_tests++;
    if (q_dmem !== 32'hCAFE_0001 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ram_top got %h e=%b req cafe0001 e=0", q_dmem, err_flag);
    end
  endtask

  task automatic test_oob();
    wr(A_OOB, 32'h55);
    n_tests++;
    if (err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_err got %b req 1", err_flag);
    end
    rd(A_OOB);
    n_tests++;
    if (q_dmem !== 32'h0) begin
      n_fail++;
      $display("FAIL oob_rd got %h req 0", q_dmem);
    end
    rd(32'd0);
    n_tests++;
    if (q_dmem !== 32'h0) begin
      n_fail++;
      $display("FAIL oob_no_wrap got %h req 0", q_dmem);
    end
`ifdef DMEM_MMIO_EN
    rd(A_ST);
    n_tests++;
    if (q_dmem !== 32'h0000_0900) begin
      n_fail++;
      $display("FAIL status_oob got %h req 00000900", q_dmem);
    end
    wr(A_CLR, 32'h0);
    n_tests++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL clear got %b req 0", err_flag);
    end
`endif
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      wr(A_TX, 32'(i));
    rd(A_ST);
    n_tests++;
    if (q_dmem !== 32'h0000_0604 || err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_status got %h e=%b req 00000604 e=1", q_dmem, err_flag);
    end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin
        n_fail++;
        $display("FAIL drain_%0d got v=%b d=%h req v=1 d=%h", i, tx_valid, tx_data, 32'(i));
      end
      step();
    end
    tx_ready = 1'b0;
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL drained got v=%b d=%h req 0/0", tx_valid, tx_data);
    end
    wr(A_CLR, 32'h0);
    rd(A_ST);
    n_tests++;
    if (q_dmem !== 32'h0000_0100 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL status_empty got %h e=%b req 00000100 e=0", q_dmem, err_flag);
    end
  endtask

  task automatic test_fifo_simul();
    tx_ready = 1'b0;
    wr(A_TX, 32'h11);
    n_tests++;
    if (tx_data !== 32'h11 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL one_entry got v=%b d=%h req 1/11", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wr(A_TX, 32'hA5);
    tx_ready = 1'b0;
    rd(A_ST);
    n_tests++;
    if (tx_data !== 32'hA5 || q_dmem !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL push_pop got d=%h st=%h req a5/00000001", tx_data, q_dmem);
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop got v=%b req 0", tx_valid);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] c1;
    rd(A_CYC);
    c1 = q_dmem;
    rd(A_CYC);
    n_tests++;
    if (q_dmem !== c1 + 32'd1) begin
      n_fail++;
      $display("FAIL cycle_inc got %h req %h", q_dmem, c1 + 32'd1);
    end
    address_dmem = A_CYC;
    force dut.r_cycle = 32'hFFFF_FFFF;
    step();
    release dut.r_cycle;
    n_tests++;
    if (q_dmem !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL cycle_max got %h req ffffffff", q_dmem);
    end
    step();
    step();
    n_tests++;
    if (q_dmem !== 32'h0) begin
      n_fail++;
      $display("FAIL cycle_wrap got %h req 0", q_dmem);
    end
    address_dmem = '0;
  endtask
`else
  task automatic test_mmio_off();
    tx_ready = 1'b1;
    wr(A_TX, 32'h7);
    n_tests++;
    if (err_flag !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mmio_off got e=%b v=%b d=%h req 1/0/0", err_flag, tx_valid, tx_data);
    end
    rd(A_ST);
    n_tests++;
    if (q_dmem !== 32'h0) begin
      n_fail++;
      $display("FAIL mmio_off_rd got %h req 0", q_dmem);
    end
    tx_ready = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    tx_ready = 1'b0;
`ifdef DMEM_MMIO_EN
    for (int i = 0; i < 3; i++)
      wr(A_TX, 32'h100 + 32'(i));
    n_tests++;
    if (tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL queued got v=%b req 1", tx_valid);
    end
`endif
    wr(A_OOB, 32'h1);
    rd(32'd5);
    reset = 1'b0;
    #1;
    n_tests++;
    if (tx_valid !== 1'b0 || q_dmem !== 32'h0 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got v=%b q=%h e=%b req 0", tx_valid, q_dmem, err_flag);
    end
    step();
    reset = 1'b1;
    step();
    rd(32'd5);
    n_tests++;
    if (q_dmem !== 32'hDEAD_BEEF || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ram_kept got %h v=%b req deadbeef v=0", q_dmem, tx_valid);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_ram();
    test_oob();
`ifdef DMEM_MMIO_EN
    test_fifo_overflow();
    test_fifo_simul();
    test_cycle();
`else
    test_mmio_off();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
